// File: rtl/mod_exp_engine.sv
`default_nettype none
// ============================================================================
// Module      : mod_exp_engine
// Description : Modular exponentiation, result = base^exponent mod modulus.
//               Right-to-left square-and-multiply. Every modular product is
//               formed by a bit-serial interleaved shift-subtract multiplier,
//               which consumes one multiplier bit per cycle, MSB first.
//               Optional macro MOD_EXP_EARLY_EXIT_EN: stop once the remaining
//               exponent is zero. Latency then depends on the data. Without
//               the macro, latency is constant and timing-safe.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_engine #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     result,
    output logic                 ready,
    output logic                 done,
    output logic                 error
);

    localparam int c_BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_EW = $clog2(EXP_WIDTH + 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(WIDTH - 1);
    localparam logic [c_EW-1:0] c_EXP_CNT   = c_EW'(EXP_WIDTH);
    localparam logic [c_EW-1:0] c_EXP_ONE   = c_EW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_MULT   = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_base;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [WIDTH-1:0]       r_mod;
    logic [WIDTH-1:0]       r_r;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH:0]         r_acc_p;
    logic [WIDTH:0]         r_acc_s;
    logic [c_BW-1:0]        r_bitidx;
    logic [c_EW-1:0]        r_expcnt;
    logic [WIDTH-1:0]       r_result;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_error;

    logic [WIDTH:0]         w_red_next;
    logic [WIDTH:0]         w_prod_next;
    logic [WIDTH:0]         w_sq_next;
    logic [WIDTH-1:0]       w_r_init;
    logic [WIDTH-1:0]       w_r_next;
    logic [EXP_WIDTH-1:0]   w_exp_shift;
    logic                   w_finish;

    // One serial multiplier step. acc < m on entry, so each correction needs
    // at most one subtraction, and every intermediate value stays below 2m.
    function automatic logic [WIDTH:0] f_serial_step(
        input logic [WIDTH:0]   acc,
        input logic [WIDTH-1:0] x,
        input logic             mbit,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] mm;
        mm = {1'b0, m};
        t  = acc << 1;
        if (t >= mm) t = t - mm;
        if (mbit)    t = t + {1'b0, x};
        if (t >= mm) t = t - mm;
        return t;
    endfunction

    // Datapath: base reduction, product r*b and square b*b. Both products
    // consume the bits of b.
    assign w_red_next  = f_serial_step(r_acc_p, WIDTH'(1), r_base[r_bitidx], r_mod);
    assign w_prod_next = f_serial_step(r_acc_p, r_r,       r_b[r_bitidx],    r_mod);
    assign w_sq_next   = f_serial_step(r_acc_s, r_b,       r_b[r_bitidx],    r_mod);
    assign w_r_init    = (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
    assign w_r_next    = r_exp[0] ? r_acc_p[WIDTH-1:0] : r_r;
    assign w_exp_shift = r_exp >> 1;

`ifdef MOD_EXP_EARLY_EXIT_EN
    assign w_finish = (r_expcnt == c_EXP_ONE) || (w_exp_shift == '0);
`else
    assign w_finish = (r_expcnt == c_EXP_ONE);
`endif

    assign result = r_result;
    assign ready  = r_ready;
    assign done   = r_done;
    assign error  = r_error;

    // Control FSM plus the operand, accumulator and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_r      <= '0;
            r_b      <= '0;
            r_acc_p  <= '0;
            r_acc_s  <= '0;
            r_bitidx <= '0;
            r_expcnt <= '0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base;
                        r_exp   <= exponent;
                        r_mod   <= modulus;
                        r_error <= 1'b0;
                        if (modulus == '0) begin
                            r_result <= '0;
                            r_error  <= 1'b1;
                            r_done   <= 1'b1;
                        end else begin
                            r_ready  <= 1'b0;
                            r_acc_p  <= '0;
                            r_acc_s  <= '0;
                            r_bitidx <= c_BIT_LAST;
                            r_state  <= S_REDUCE;
                        end
                    end
                end
                S_REDUCE: begin
                    r_acc_p <= w_red_next;
                    if (r_bitidx == '0) begin
                        r_b      <= w_red_next[WIDTH-1:0];
                        r_r      <= w_r_init;
                        r_acc_p  <= '0;
                        r_bitidx <= c_BIT_LAST;
                        r_expcnt <= c_EXP_CNT;
`ifdef MOD_EXP_EARLY_EXIT_EN
                        if (r_exp == '0) begin
                            r_result <= w_r_init;
                            r_done   <= 1'b1;
                            r_ready  <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_state <= S_MULT;
                        end
`else
                        r_state <= S_MULT;
`endif
                    end else begin
                        r_bitidx <= r_bitidx - c_BW'(1);
                    end
                end
                S_MULT: begin
                    r_acc_p <= w_prod_next;
                    r_acc_s <= w_sq_next;
                    if (r_bitidx == '0) begin
                        r_state <= S_STEP;
                    end else begin
                        r_bitidx <= r_bitidx - c_BW'(1);
                    end
                end
                S_STEP: begin
                    r_r      <= w_r_next;
                    r_b      <= r_acc_s[WIDTH-1:0];
                    r_exp    <= w_exp_shift;
                    r_expcnt <= r_expcnt - c_EXP_ONE;
                    r_acc_p  <= '0;
                    r_acc_s  <= '0;
                    r_bitidx <= c_BIT_LAST;
                    if (w_finish) begin
                        r_result <= w_r_next;
                        r_done   <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_state <= S_MULT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_exp_engine
// Description : Directed self-checking bench for mod_exp_engine. It uses an
//               8-bit instance and a 16-bit instance. Expected values are
//               computed by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp_engine;

`ifdef MOD_EXP_EARLY_EXIT_EN
    localparam bit c_EARLY = 1'b1;
`else
    localparam bit c_EARLY = 1'b0;
`endif

    logic        clk;
    logic        reset;

    logic        start8;
    logic [7:0]  base8, exp8, mod8, res8;
    logic        rdy8, done8, err8;

    logic        start16;
    logic [15:0] base16, exp16, mod16, res16;
    logic        rdy16, done16, err16;

    int n_tests;
    int n_fail;

    mod_exp_engine #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .base(base8),
        .exponent(exp8), .modulus(mod8), .result(res8),
        .ready(rdy8), .done(done8), .error(err8)
    );

    mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .base(base16),
        .exponent(exp16), .modulus(mod16), .result(res16),
        .ready(rdy16), .done(done16), .error(err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Runs one job on the selected instance. It then checks the done edge,
    // the result, the error flag and the single-cycle done pulse.
    task automatic run_job(input bit w16, input logic [15:0] b, input logic [15:0] e,
                           input logic [15:0] m, input logic [15:0] expr,
                           input bit experr, input int expedge, input bit hold,
                           input string tag);
        int edge_n;
        @(negedge clk);
        if (w16) begin
            base16 = b; exp16 = e; mod16 = m; start16 = 1'b1;
        end else begin
            base8 = b[7:0]; exp8 = e[7:0]; mod8 = m[7:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            start8  = 1'b0;
            start16 = 1'b0;
        end
        // The engine latched its operands at acceptance, so changing the inputs now must not matter.
        base8 = ~base8; exp8 = ~exp8; mod8 = ~mod8;
        base16 = ~base16; exp16 = ~exp16; mod16 = ~mod16;
        if (m != 16'd0) begin
            chk({tag, "_busy_ready"}, {63'd0, (w16 ? rdy16 : rdy8)}, 64'd0);
            chk({tag, "_busy_error"}, {63'd0, (w16 ? err16 : err8)}, 64'd0);
        end
        edge_n = 0;
        while (!(w16 ? done16 : done8) && edge_n < 2000) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
        start8  = 1'b0;
        start16 = 1'b0;
        chk({tag, "_done_edge"}, 64'(edge_n), 64'(expedge));
        chk({tag, "_result"}, (w16 ? {48'd0, res16} : {56'd0, res8}), {48'd0, expr});
        chk({tag, "_error"}, {63'd0, (w16 ? err16 : err8)}, {63'd0, experr});
        chk({tag, "_ready"}, {63'd0, (w16 ? rdy16 : rdy8)}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {63'd0, (w16 ? done16 : done8)}, 64'd0);
        chk({tag, "_result_hold"}, (w16 ? {48'd0, res16} : {56'd0, res8}), {48'd0, expr});
        chk({tag, "_error_hold"}, {63'd0, (w16 ? err16 : err8)}, {63'd0, experr});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        start8  = 1'b0; base8  = '0; exp8  = '0; mod8  = '0;
        start16 = 1'b0; base16 = '0; exp16 = '0; mod16 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", {56'd0, res8}, 64'd0);
        chk("rst_ready",  {63'd0, rdy8}, 64'd1);
        chk("rst_done",   {63'd0, done8}, 64'd0);
        chk("rst_error",  {63'd0, err8}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 3^5 mod 7 = 5. The highest set exponent bit is bit 2, so k = 3.
        run_job(1'b0, 16'd3, 16'd5, 16'd7, 16'd5, 1'b0, c_EARLY ? 35 : 80, 1'b0, "basic");
        // 10^3 mod 7 = 6. Here k = 2.
        run_job(1'b0, 16'd10, 16'd3, 16'd7, 16'd6, 1'b0, c_EARLY ? 26 : 80, 1'b0, "base_red");
        // 2^10 mod 1000 = 24 at WIDTH=16. Here k = 4.
        run_job(1'b1, 16'd2, 16'd10, 16'd1000, 16'd24, 1'b0, c_EARLY ? 84 : 288, 1'b0, "w16");
        // An exponent of 0 gives 1.
        run_job(1'b0, 16'd5, 16'd0, 16'd7, 16'd1, 1'b0, c_EARLY ? 8 : 80, 1'b0, "exp0");
        // A modulus of 1 gives 0. The exponent 77 = 1001101b, so k = 7.
        run_job(1'b0, 16'd200, 16'd77, 16'd1, 16'd0, 1'b0, c_EARLY ? 71 : 80, 1'b0, "mod1");
        // 0^0 mod 5 = 1.
        run_job(1'b0, 16'd0, 16'd0, 16'd5, 16'd1, 1'b0, c_EARLY ? 8 : 80, 1'b0, "zero_zero");
        // A modulus of 0 is illegal: error is raised and done comes at edge 0.
        run_job(1'b0, 16'd9, 16'd4, 16'd0, 16'd0, 1'b1, 0, 1'b0, "mod0");
        // Start is held high through the whole busy period. This job must also clear error.
        // 255 mod 251 = 4, and 4^255 = 4^5 * (4^250 = 1), so the result is 1024 mod 251 = 20.
        run_job(1'b0, 16'd255, 16'd255, 16'd251, 16'd20, 1'b0, 80, 1'b1, "hold_start");
        // Back-to-back jobs. 2^128 mod 255 = 1, because 2^8 = 256 is 1 mod 255.
        run_job(1'b0, 16'd2, 16'd128, 16'd255, 16'd1, 1'b0, 80, 1'b0, "b2b_a");
        // 7^2 mod 13 = 49 mod 13 = 10.
        run_job(1'b0, 16'd7, 16'd2, 16'd13, 16'd10, 1'b0, c_EARLY ? 26 : 80, 1'b0, "b2b_b");

        // Reset in the middle of a job, at edge 20.
        @(negedge clk);
        base8 = 8'd3; exp8 = 8'd5; mod8 = 8'd7; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy_ready", {63'd0, rdy8}, 64'd0);
        chk("mid_prev_result", {56'd0, res8}, 64'd10);
        reset = 1'b0;
        #1;
        chk("mid_rst_result", {56'd0, res8}, 64'd0);
        chk("mid_rst_ready",  {63'd0, rdy8}, 64'd1);
        chk("mid_rst_done",   {63'd0, done8}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_done", {63'd0, done8}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_job(1'b0, 16'd3, 16'd5, 16'd7, 16'd5, 1'b0, c_EARLY ? 35 : 80, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
